// File: rtl/cs_sync_pkg.sv
// cs_sync_pkg: shared state encoding, default sizing and event type for the lock-step controller
package cs_sync_pkg;
   localparam int N_CLK_DEF    = 4;
   localparam int DATA_W_DEF   = 9;
   localparam int WDOG_MAX_DEF = 10000;
   typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP, HALT} state_t;
   typedef logic [$clog2(N_CLK_DEF)-1:0] evt_t;
endpackage

// File: rtl/part_1_edge_det.sv
// part_1_edge_det: enabled rising-edge detection of mission clocks sampled as levels
module part_1_edge_det #(
   parameter int N = 4
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [N-1:0] clk_h,
   input  logic [N-1:0] clk_en,
   output logic [N-1:0] rise
);
   logic [N-1:0] clk_h_d;
   // one-cycle delayed copy of the mission clock levels
   always_ff @(posedge clk_i) clk_h_d <= rst_i ? '0 : clk_h;
   assign rise = clk_h & ~clk_h_d & clk_en;
endmodule

// File: rtl/part_1_init_sync_ctrl.sv
// part_1_init_sync_ctrl: freezes mission clocks on each edge, ships the snapshot, releases on the target's response
module part_1_init_sync_ctrl
   import cs_sync_pkg::*;
#(
   parameter int N_CLK    = N_CLK_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int WDOG_MAX = WDOG_MAX_DEF
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [N_CLK-1:0]         clk_h,
   input  logic [N_CLK-1:0]         clk_en,
   input  logic [N_CLK*DATA_W-1:0]  snd_data,
   output logic [N_CLK-1:0]         freeze_clk,
   output logic                     tx_valid,
   input  logic                     tx_ready,
   output logic [$clog2(N_CLK)-1:0] tx_event,
   output logic [DATA_W-1:0]        tx_payload,
   input  logic                     rx_valid,
   input  logic [$clog2(N_CLK)-1:0] rx_event,
   input  logic [DATA_W-1:0]        rx_payload,
   output logic [N_CLK-1:0]         rsp_valid,
   output logic [N_CLK*DATA_W-1:0]  rsp_data,
   output logic                     busy,
   output logic                     evt_err,
   output logic                     ovr_err,
   output logic                     wdog_err
);
   localparam int EW = $clog2(N_CLK);
   localparam int WW = $clog2(WDOG_MAX + 1);
   state_t            state, state_n;
   logic [N_CLK-1:0]  rise, pend, clr;
   logic [DATA_W-1:0] snap [N_CLK];
   logic [EW-1:0]     sel, low;
   logic [WW-1:0]     wdog;
   logic              acc, hit, bad, expire;
   part_1_edge_det #(.N(N_CLK)) u_edge (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .clk_h  (clk_h),
      .clk_en (clk_en),
      .rise   (rise)
   );
   // handshake events; a matching response wins over a watchdog expiry in the same cycle
   always_comb begin
      acc    = state == SEND && tx_ready;
      hit    = state == WAIT_RSP && rx_valid && rx_event == sel;
      bad    = rx_valid && (state == IDLE || state == SEND || (state == WAIT_RSP && rx_event != sel));
      expire = state == WAIT_RSP && !hit && wdog + WW'(1) == WW'(WDOG_MAX);
      clr    = hit ? N_CLK'(1) << sel : '0;
   end
   // lowest pending slot is served first
   always_comb begin
      low = '0;
      for (int k = N_CLK - 1; k >= 0; k--) if (pend[k]) low = EW'(k);
   end
   // state register
   always_ff @(posedge clk_i) state <= rst_i ? IDLE : state_n;
   // next-state selection; HALT is left only through reset
   always_comb begin
      state_n = state;
      case (state)
         IDLE:     state_n = |pend ? SEND : IDLE;
         SEND:     state_n = tx_ready ? WAIT_RSP : SEND;
         WAIT_RSP: state_n = hit ? IDLE : expire ? HALT : WAIT_RSP;
         default:  state_n = HALT;
      endcase
   end
   // transport offer and status outputs; a pending slot is exactly a frozen clock
   always_comb begin
      tx_valid   = state == SEND;
      tx_event   = tx_valid ? sel : '0;
      tx_payload = tx_valid ? snap[sel] : '0;
      busy       = state != IDLE;
      freeze_clk = pend;
   end
   // pending set/release, arbitration, watchdog, sticky errors and response capture
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pend      <= '0;
         sel       <= '0;
         wdog      <= '0;
         rsp_valid <= '0;
         rsp_data  <= '0;
         evt_err   <= 1'b0;
         ovr_err   <= 1'b0;
         wdog_err  <= 1'b0;
      end else begin
         pend      <= (pend & ~clr) | rise;
         ovr_err   <= ovr_err | |(rise & pend & ~clr);
         evt_err   <= evt_err | bad;
         wdog_err  <= wdog_err | expire;
         rsp_valid <= clr;
         wdog      <= acc ? '0 : state == WAIT_RSP ? wdog + WW'(1) : wdog;
         if (state == IDLE) sel <= low;
         if (hit) rsp_data[sel*DATA_W +: DATA_W] <= rx_payload;
      end
   end
   // snapshot only when the slot is free or being released this same cycle
   always_ff @(posedge clk_i)
      for (int k = 0; k < N_CLK; k++)
         if (rst_i) snap[k] <= '0;
         else if (rise[k] & (~pend[k] | clr[k])) snap[k] <= snd_data[k*DATA_W +: DATA_W];
endmodule

// File: tb/tb_part_1_init_sync_ctrl.sv
// tb_part_1_init_sync_ctrl: vector table, directed corner sequences and randomized model check
module tb_part_1_init_sync_ctrl;
   import cs_sync_pkg::*;
   localparam int WD = 16;
   logic        clk_i = 1'b0, rst_i, tx_ready, rx_valid;
   logic [3:0]  clk_h, clk_en, freeze_clk, rsp_valid;
   logic [35:0] snd_data, rsp_data;
   logic [8:0]  tx_payload, rx_payload;
   evt_t        tx_event, rx_event;
   logic        tx_valid, busy, evt_err, ovr_err, wdog_err;
   int          n_cmp = 0, n_bad = 0;
   always #5 clk_i = ~clk_i;
   part_1_init_sync_ctrl #(.N_CLK(4), .DATA_W(9), .WDOG_MAX(WD)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .clk_h(clk_h), .clk_en(clk_en), .snd_data(snd_data),
      .freeze_clk(freeze_clk), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_event(tx_event),
      .tx_payload(tx_payload), .rx_valid(rx_valid), .rx_event(rx_event), .rx_payload(rx_payload),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy), .evt_err(evt_err),
      .ovr_err(ovr_err), .wdog_err(wdog_err)
   );
   typedef struct packed {
      logic [3:0] h; logic [35:0] d; logic rdy, rxv; logic [1:0] rxe; logic [8:0] rxp;
      logic [3:0] frz; logic txv; logic [1:0] txe; logic [8:0] txp; logic [3:0] rv; logic bsy; logic [2:0] err;
   } vec_t;
   vec_t tbl[$];
   function automatic vec_t v(logic [3:0] h, logic [35:0] d, logic rdy, rxv, logic [1:0] rxe, logic [8:0] rxp,
                              logic [3:0] frz, logic txv, logic [1:0] txe, logic [8:0] txp, logic [3:0] rv, logic bsy, logic [2:0] err);
      return '{h: h, d: d, rdy: rdy, rxv: rxv, rxe: rxe, rxp: rxp, frz: frz, txv: txv, txe: txe, txp: txp, rv: rv, bsy: bsy, err: err};
   endfunction
   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask
   task automatic cyc;
      @(posedge clk_i);
      #1;
   endtask
   task automatic chk_out(string t, logic [3:0] frz, logic txv, logic [1:0] txe, logic [8:0] txp, logic [3:0] rv, logic bsy, logic [2:0] err);
      chk({t, ".freeze"}, freeze_clk, frz);
      chk({t, ".tx_valid"}, tx_valid, txv);
      chk({t, ".tx_event"}, tx_event, txe);
      chk({t, ".tx_payload"}, tx_payload, txp);
      chk({t, ".rsp_valid"}, rsp_valid, rv);
      chk({t, ".busy"}, busy, bsy);
      chk({t, ".err"}, {evt_err, ovr_err, wdog_err}, err);
   endtask
   // reference model: set of pending slots plus the one transaction in flight
   logic [3:0] mp, mhd, mrv;
   logic [8:0] ms [4], mr [4];
   bit         me, mo, mw, off, wt, hlt;
   int         cur, waited;
   task automatic m_reset;
      mp = 0; mhd = 0; mrv = 0; me = 0; mo = 0; mw = 0; off = 0; wt = 0; hlt = 0; cur = -1; waited = 0;
      for (int k = 0; k < 4; k++) begin ms[k] = 0; mr[k] = 0; end
   endtask
   task automatic m_step;
      logic [3:0] rise, np;
      int rel;
      if (rst_i) begin
         m_reset;
         return;
      end
      rise = clk_h & ~mhd & clk_en;
      mhd = clk_h;
      rel = (wt && rx_valid && int'(rx_event) == cur) ? cur : -1;
      me |= rx_valid && !hlt && rel < 0;
      np = mp;
      mrv = 0;
      if (rel >= 0) begin np[rel] = 0; mrv[rel] = 1; mr[rel] = rx_payload; end
      for (int k = 0; k < 4; k++)
         if (rise[k]) begin
            if (mp[k] && k != rel) mo = 1;
            else begin np[k] = 1; ms[k] = snd_data[k*9 +: 9]; end
         end
      if (!hlt) begin
         if (cur < 0) begin
            for (int k = 3; k >= 0; k--) if (mp[k]) begin cur = k; off = 1; end
         end else if (off) begin
            if (tx_ready) begin off = 0; wt = 1; waited = 0; end
         end else if (rel >= 0) begin
            wt = 0; cur = -1;
         end else begin
            waited++;
            if (waited == WD) begin mw = 1; hlt = 1; wt = 0; end
         end
      end
      mp = np;
   endtask
   initial begin
      #500000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1);
   end
   initial begin
      logic [35:0] d1, d2;
      d1 = {27'h0, 9'h1A5};
      d2 = {9'h0, 9'h1CD, 9'h0AB, 9'h0};
      rst_i = 1; clk_h = 0; clk_en = 4'hF; snd_data = 0; tx_ready = 0; rx_valid = 0; rx_event = 0; rx_payload = 0;
      cyc; cyc;
      chk_out("reset", 0, 0, 0, 0, 0, 0, 0);
      chk("reset.rsp_data", rsp_data, 0);
      rst_i = 0;
      cyc;
      chk_out("post_reset", 0, 0, 0, 0, 0, 0, 0);
      tbl.push_back(v(4'h1, d1, 1, 0, 0, 0,      4'h1, 0, 0, 0,      4'h0, 0, 0));
      tbl.push_back(v(4'h1, d1, 1, 0, 0, 0,      4'h1, 1, 0, 9'h1A5, 4'h0, 1, 0));
      tbl.push_back(v(4'h1, d1, 1, 0, 0, 0,      4'h1, 0, 0, 0,      4'h0, 1, 0));
      for (int i = 0; i < 4; i++) tbl.push_back(v(4'h0, d1, 1, 0, 0, 0, 4'h1, 0, 0, 0, 4'h0, 1, 0));
      tbl.push_back(v(4'h0, d1, 1, 1, 0, 9'h07F, 4'h0, 0, 0, 0,      4'h1, 0, 0));
      tbl.push_back(v(4'h0, d1, 1, 0, 0, 0,      4'h0, 0, 0, 0,      4'h0, 0, 0));
      tbl.push_back(v(4'h6, d2, 1, 0, 0, 0,      4'h6, 0, 0, 0,      4'h0, 0, 0));
      tbl.push_back(v(4'h6, d2, 1, 0, 0, 0,      4'h6, 1, 1, 9'h0AB, 4'h0, 1, 0));
      tbl.push_back(v(4'h6, d2, 1, 0, 0, 0,      4'h6, 0, 0, 0,      4'h0, 1, 0));
      tbl.push_back(v(4'h6, d2, 1, 1, 1, 9'h055, 4'h4, 0, 0, 0,      4'h2, 0, 0));
      tbl.push_back(v(4'h6, d2, 1, 0, 0, 0,      4'h4, 1, 2, 9'h1CD, 4'h0, 1, 0));
      tbl.push_back(v(4'h6, d2, 1, 0, 0, 0,      4'h4, 0, 0, 0,      4'h0, 1, 0));
      tbl.push_back(v(4'h6, d2, 1, 1, 2, 9'h0AA, 4'h0, 0, 0, 0,      4'h4, 0, 0));
      tbl.push_back(v(4'h0, d2, 1, 0, 0, 0,      4'h0, 0, 0, 0,      4'h0, 0, 0));
      foreach (tbl[i]) begin
         clk_h = tbl[i].h; snd_data = tbl[i].d; tx_ready = tbl[i].rdy;
         rx_valid = tbl[i].rxv; rx_event = tbl[i].rxe; rx_payload = tbl[i].rxp;
         cyc;
         chk_out($sformatf("vec%0d", i), tbl[i].frz, tbl[i].txv, tbl[i].txe, tbl[i].txp, tbl[i].rv, tbl[i].bsy, tbl[i].err);
      end
      rx_valid = 0;
      chk("vec.rsp_data", rsp_data, {9'h0, 9'h0AA, 9'h055, 9'h07F});
      // stalled transport: offer must hold steady while the source data churns
      tx_ready = 0; snd_data = {9'h133, 27'h0}; clk_h = 4'h8;
      cyc; cyc;
      for (int i = 0; i < 20; i++) begin
         chk_out($sformatf("stall%0d", i), 4'h8, 1, 3, 9'h133, 0, 1, 0);
         snd_data = {4'($urandom), $urandom};
         cyc;
      end
      tx_ready = 1;
      cyc;
      chk_out("stall.accept", 4'h8, 0, 0, 0, 0, 1, 0);
      tx_ready = 0; rx_valid = 1; rx_event = 3; rx_payload = 9'h1FF;
      cyc;
      rx_valid = 0; clk_h = 0;
      chk_out("stall.done", 0, 0, 0, 0, 4'h8, 0, 0);
      // wrong event number while waiting
      clk_h = 4'h2; snd_data = {18'h0, 9'h044, 9'h0}; tx_ready = 1;
      cyc; cyc; cyc;
      rx_valid = 1; rx_event = 3; rx_payload = 9'h1EE;
      cyc;
      rx_valid = 0;
      chk_out("evt.bad", 4'h2, 0, 0, 0, 0, 1, 3'b100);
      cyc;
      rx_valid = 1; rx_event = 1; rx_payload = 9'h123;
      cyc;
      rx_valid = 0; clk_h = 0;
      chk_out("evt.done", 0, 0, 0, 0, 4'h2, 0, 3'b100);
      chk("evt.rsp_data", rsp_data[17:9], 9'h123);
      cyc;
      // second edge on a pending slot
      tx_ready = 0; clk_h = 4'h1; snd_data = {27'h0, 9'h0C3};
      cyc;
      clk_h = 0; snd_data = {27'h0, 9'h13C};
      cyc;
      chk_out("ovr.send", 4'h1, 1, 0, 9'h0C3, 0, 1, 3'b100);
      clk_h = 4'h1;
      cyc;
      chk_out("ovr.edge", 4'h1, 1, 0, 9'h0C3, 0, 1, 3'b110);
      tx_ready = 1;
      cyc;
      rx_valid = 1; rx_event = 0; rx_payload = 9'h099;
      cyc;
      rx_valid = 0;
      chk_out("ovr.done", 0, 0, 0, 0, 4'h1, 0, 3'b110);
      chk("ovr.rsp_data", rsp_data[8:0], 9'h099);
      clk_h = 0;
      cyc;
      // no response: watchdog fires exactly WD cycles after accept
      clk_h = 4'h4;
      cyc; cyc; cyc;
      for (int i = 1; i <= WD; i++) begin
         cyc;
         chk($sformatf("wdog@%0d", i), wdog_err, i == WD);
      end
      chk_out("halt", 4'h4, 0, 0, 0, 0, 1, 3'b111);
      rx_valid = 1; rx_event = 2; rx_payload = 9'h111;
      cyc;
      rx_valid = 0;
      chk_out("halt.rx", 4'h4, 0, 0, 0, 0, 1, 3'b111);
      chk("halt.rsp_data", rsp_data[26:18], 9'h0AA);
      clk_h = 0; rst_i = 1;
      cyc;
      rst_i = 0;
      chk_out("halt.reset", 0, 0, 0, 0, 0, 0, 0);
      chk("halt.reset.rsp_data", rsp_data, 0);
      // randomized traffic against the model
      rst_i = 1;
      cyc;
      m_reset;
      rst_i = 0;
      for (int c = 0; c < 3000; c++) begin
         rst_i = ($urandom_range(0, 499) == 0) || (hlt && $urandom_range(0, 19) == 0);
         if ($urandom_range(0, 3) == 0) clk_h = clk_h ^ 4'($urandom);
         if ($urandom_range(0, 7) == 0) clk_en = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
         snd_data = {4'($urandom), $urandom};
         tx_ready = $urandom_range(0, 2) != 0;
         rx_valid = $urandom_range(0, 3) == 0;
         rx_event = (cur >= 0 && $urandom_range(0, 3) != 0) ? 2'(cur) : 2'($urandom);
         rx_payload = 9'($urandom);
         cyc;
         m_step;
         chk_out($sformatf("rnd%0d", c), mp, off, off ? 2'(cur) : 2'd0, off ? ms[cur] : 9'h0, mrv, cur >= 0 || hlt, {me, mo, mw});
         chk($sformatf("rnd%0d.rsp_data", c), rsp_data, {mr[3], mr[2], mr[1], mr[0]});
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
